// File: rtl/snitch_regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the Snitch integer register file.
// One registered write port; producers handshake via valid/ready.
module snitch_regfile_wb_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned NR_SRC        = 3,
    parameter bit          ZERO_REG_ZERO = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NR_SRC-1:0]                    src_valid_i,
    input  logic [NR_SRC-1:0][ADDR_WIDTH-1:0]    src_addr_i,
    input  logic [NR_SRC-1:0][DATA_WIDTH-1:0]    src_data_i,
    output logic [NR_SRC-1:0]                    src_ready_o,
    output logic                                 we_o,
    output logic [ADDR_WIDTH-1:0]                waddr_o,
    output logic [DATA_WIDTH-1:0]                wdata_o,
    output logic                                 busy_o
);

    localparam int unsigned PW = $clog2(NR_SRC);

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         gnt_idx;
    logic [PW-1:0]         idx;
    logic                  found;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  zero_hit;

    // Scan starting at the pointer; the first valid source wins.
    always_comb begin
        src_ready_o = '0;
        gnt_idx     = '0;
        idx         = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < NR_SRC; i++) begin
            idx = PW'((32'(ptr_q) + i) % NR_SRC);
            if (!found && src_valid_i[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found) begin
            src_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        if (gnt_idx == PW'(NR_SRC - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx + PW'(1);
        end
    end

    assign zero_hit = ZERO_REG_ZERO && (src_addr_i[gnt_idx] == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= found && !zero_hit;
            if (found) begin
                ptr_q   <= ptr_d;
                waddr_q <= src_addr_i[gnt_idx];
                wdata_q <= src_data_i[gnt_idx];
            end
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign busy_o  = (|src_valid_i) | we_q;

endmodule

// File: tb/tb_snitch_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter with a write scoreboard.
module tb_snitch_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         v = '0;
    logic [N-1:0][AW-1:0] addr = '0;
    logic [N-1:0][DW-1:0] data = '0;

    logic [N-1:0]  rdy, nz_rdy;
    logic          we, nz_we, busy, nz_busy;
    logic [AW-1:0] waddr, nz_waddr;
    logic [DW-1:0] wdata, nz_wdata;

    snitch_regfile_wb_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_SRC(N), .ZERO_REG_ZERO(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .src_valid_i(v), .src_addr_i(addr), .src_data_i(data),
        .src_ready_o(rdy), .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
        .busy_o(busy)
    );

    snitch_regfile_wb_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_SRC(N), .ZERO_REG_ZERO(1'b0)
    ) dut_nz (
        .clk_i(clk), .rst_ni(rst_n),
        .src_valid_i(v), .src_addr_i(addr), .src_data_i(data),
        .src_ready_o(nz_rdy), .we_o(nz_we), .waddr_o(nz_waddr),
        .wdata_o(nz_wdata), .busy_o(nz_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;
    logic [DW-1:0]    rf [32];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every register-file write must match the next queued entry.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none",
                         waddr, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(waddr), 64'(mon_e[AW+DW-1:DW]));
                chk("wr_data", 64'(wdata), 64'(mon_e[DW-1:0]));
            end
            rf[waddr] = wdata;
        end
    end

    logic [N-1:0]         pv = '0, pr = '0;
    logic [N-1:0][AW-1:0] pa = '0;
    logic [N-1:0][DW-1:0] pd = '0;
    logic                 prst = 1'b0;

    // Producer rule: a pending request holds valid, addr and data.
    always @(posedge clk) begin
        if (prst && rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (pv[i] && !pr[i])
                    chk("producer_hold", 64'({v[i], addr[i], data[i]}),
                        64'({1'b1, pa[i], pd[i]}));
            end
        end
        pv = v; pr = rdy; pa = addr; pd = data; prst = rst_n;
    end

    task automatic step(input logic [N-1:0] vv,
                        input logic [N-1:0][AW-1:0] aa,
                        input logic [N-1:0][DW-1:0] dd,
                        input logic [N-1:0] er, input logic ew);
        @(posedge clk);
        #1;
        v = vv; addr = aa; data = dd;
        #1;
        chk("ready", 64'(rdy), 64'(er));
        chk("we", 64'(we), 64'(ew));
        chk("busy", 64'(busy), 64'((|vv) | ew));
        for (int i = 0; i < N; i++)
            if (er[i] && aa[i] != '0) exp_q.push_back({aa[i], dd[i]});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        #12;
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_waddr", 64'(waddr), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("rst_ready", 64'(rdy), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // single source
        step(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b001, 1'b0);
        step(3'b000, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b000, 1'b1);
        step(3'b000, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b000, 1'b0);
        // p=1 -> grant source 2 moves pointer to 0
        step(3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 3'b100, 1'b0);
        // round robin, twice
        step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b001, 1'b1);
        step(3'b110, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b010, 1'b1);
        step(3'b100, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b100, 1'b1);
        step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h66, 32'h55, 32'h44}, 3'b001, 1'b1);
        step(3'b110, {5'd3, 5'd2, 5'd1}, {32'h66, 32'h55, 32'h44}, 3'b010, 1'b1);
        step(3'b100, {5'd3, 5'd2, 5'd1}, {32'h66, 32'h55, 32'h44}, 3'b100, 1'b1);
        // wrap after grant to source 2
        step(3'b011, {5'd0, 5'd6, 5'd4}, {32'h0, 32'hB6, 32'hA4}, 3'b001, 1'b1);
        step(3'b010, {5'd0, 5'd6, 5'd4}, {32'h0, 32'hB6, 32'hA4}, 3'b010, 1'b1);
        step(3'b000, {5'd0, 5'd6, 5'd4}, {32'h0, 32'hB6, 32'hA4}, 3'b000, 1'b1);
        step(3'b000, {5'd0, 5'd6, 5'd4}, {32'h0, 32'hB6, 32'hA4}, 3'b000, 1'b0);
        // zero register, p=2
        step(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 3'b010, 1'b0);
        step(3'b000, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 3'b000, 1'b0);
        chk("zero_waddr", 64'(waddr), 64'(0));
        chk("zero_wdata", 64'(wdata), 64'(32'h1234));
        chk("nz_we", 64'(nz_we), 64'(1));
        chk("nz_waddr", 64'(nz_waddr), 64'(0));
        chk("nz_wdata", 64'(nz_wdata), 64'(32'h1234));
        // same address ordering, bring p to 0 first
        step(3'b100, {5'd8, 5'd0, 5'd0}, {32'h88, 32'h0, 32'h0}, 3'b100, 1'b0);
        step(3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hB, 32'hA}, 3'b001, 1'b1);
        step(3'b010, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hB, 32'hA}, 3'b010, 1'b1);
        step(3'b000, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hB, 32'hA}, 3'b000, 1'b1);
        step(3'b000, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hB, 32'hA}, 3'b000, 1'b0);
        chk("rf_same_addr", 64'(rf[7]), 64'(32'hB));
        // reset mid-operation: the granted write must never appear
        step(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'hC3}, 3'b001, 1'b0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        v = 3'b111;
        addr = {5'd3, 5'd2, 5'd1};
        data = {32'hE3, 32'hE2, 32'hE1};
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 64'(we), 64'(0));
        chk("midrst_waddr", 64'(waddr), 64'(0));
        chk("midrst_wdata", 64'(wdata), 64'(0));
        chk("midrst_ready", 64'(rdy), 64'(3'b001));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(rdy), 64'(3'b001));
        exp_q.push_back({5'd1, 32'hE1});
        step(3'b110, {5'd3, 5'd2, 5'd1}, {32'hE3, 32'hE2, 32'hE1}, 3'b010, 1'b1);
        step(3'b100, {5'd3, 5'd2, 5'd1}, {32'hE3, 32'hE2, 32'hE1}, 3'b100, 1'b1);
        step(3'b000, {5'd3, 5'd2, 5'd1}, {32'hE3, 32'hE2, 32'hE1}, 3'b000, 1'b1);
        step(3'b000, {5'd3, 5'd2, 5'd1}, {32'hE3, 32'hE2, 32'hE1}, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        chk("rf_final_7", 64'(rf[7]), 64'(32'hB));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
